// File: rtl/cache_request_master.sv
// cache_request_master: master side of the cache request interface.
// Trace commands are queued in a small FIFO, then replayed one at a time over
// the 4-phase request/valid handshake. Each completion is reported as a
// one-cycle rsp_valid pulse carrying the op code, read data and evict flag.
// Optional build macro: CACHE_REQ_STATS_EN adds saturating read/write/evict
// counters that an op 8 (clear) completion resets.

module cache_request_master #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int DEPTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [ADDRESSWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0]    cmd_data,
  output logic [3:0]              operation,
  output logic [ADDRESSWIDTH-1:0] addr_out,
  output logic [DATAWIDTH-1:0]    data_out,
  output logic                    data_oe,
  input  logic [DATAWIDTH-1:0]    data_in,
  output logic                    request,
  input  logic                    valid,
  input  logic                    evict,
  output logic                    rsp_valid,
  output logic [3:0]              rsp_op,
  output logic [DATAWIDTH-1:0]    rsp_data,
  output logic                    rsp_evict,
  output logic                    busy
`ifdef CACHE_REQ_STATS_EN
  ,
  output logic [31:0]             stat_reads,
  output logic [31:0]             stat_writes,
  output logic [31:0]             stat_evicts
`endif
);

  // state   | meaning
  // IDLE    | no transaction; pops the FIFO head once valid is low
  // REQ     | request high, command held on the bus, waiting for valid
  // RELEASE | request dropped, waiting for valid low to close the handshake

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;

  logic [3:0]              fifo_op   [DEPTH];
  logic [ADDRESSWIDTH-1:0] fifo_addr [DEPTH];
  logic [DATAWIDTH-1:0]    fifo_data [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Read data and evict are captured at the acknowledge but only published
  // at completion, so the rsp_* outputs hold steady between pulses.
  logic [DATAWIDTH-1:0] cap_data;
  logic                 cap_evict;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // A still-high valid in IDLE is a stale acknowledge; never start over it.
  assign pop       = (state == IDLE) && !empty && !valid;
  assign busy      = !empty || (state != IDLE);

  // FIFO storage; write data is only meaningful for writes, so it is zeroed otherwise.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_op[wptr]   <= cmd_op;
      fifo_addr[wptr] <= cmd_addr;
      fifo_data[wptr] <= (cmd_op == 4'd1) ? cmd_data : '0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Handshake FSM with all bus and response outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      operation <= '0;
      addr_out  <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      request   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_op    <= '0;
      rsp_data  <= '0;
      rsp_evict <= 1'b0;
      cap_data  <= '0;
      cap_evict <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            operation <= fifo_op[rptr];
            addr_out  <= fifo_addr[rptr];
            data_out  <= fifo_data[rptr];
            data_oe   <= (fifo_op[rptr] == 4'd1);
            request   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (valid) begin
            cap_data  <= ((operation == 4'd0) || (operation == 4'd2)) ? data_in : '0;
            cap_evict <= evict;
            request   <= 1'b0;
            data_oe   <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!valid) begin
            rsp_valid <= 1'b1;
            rsp_op    <= operation;
            rsp_data  <= cap_data;
            rsp_evict <= cap_evict;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_REQ_STATS_EN
  // Completion statistics; a clear completion wins over any increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_evicts <= '0;
    end else if (rsp_valid) begin
      if (rsp_op == 4'd8) begin
        stat_reads  <= '0;
        stat_writes <= '0;
        stat_evicts <= '0;
      end else begin
        if (((rsp_op == 4'd0) || (rsp_op == 4'd2)) && (stat_reads != 32'hFFFF_FFFF))
          stat_reads <= stat_reads + 32'd1;
        if ((rsp_op == 4'd1) && (stat_writes != 32'hFFFF_FFFF))
          stat_writes <= stat_writes + 32'd1;
        if (rsp_evict && (stat_evicts != 32'hFFFF_FFFF))
          stat_evicts <= stat_evicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_request_master.sv
// Bench for cache_request_master: a behavioural cache slave answers the
// 4-phase handshake, a monitor logs bus issues and responses, and each test
// task compares those logs with responses predicted from the pushed commands.

module tb_cache_request_master;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [3:0]    operation;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic [DW-1:0] data_in;
  logic          request;
  logic          valid;
  logic          evict;
  logic          rsp_valid;
  logic [3:0]    rsp_op;
  logic [DW-1:0] rsp_data;
  logic          rsp_evict;
  logic          busy;
`ifdef CACHE_REQ_STATS_EN
  logic [31:0]   stat_reads, stat_writes, stat_evicts;
`endif

  cache_request_master #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .operation(operation), .addr_out(addr_out), .data_out(data_out),
    .data_oe(data_oe), .data_in(data_in), .request(request), .valid(valid),
    .evict(evict), .rsp_valid(rsp_valid), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .rsp_evict(rsp_evict), .busy(busy)
`ifdef CACHE_REQ_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_evicts(stat_evicts)
`endif
  );

  typedef struct { logic [3:0] op; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
  typedef struct { logic [DW-1:0] data; logic evict; } ack_t;
  typedef struct { logic [3:0] op; logic [AW-1:0] addr; logic [DW-1:0] data; logic oe; int cyc; } issue_t;
  typedef struct { logic [3:0] op; logic [DW-1:0] data; logic evict; int cyc; } rsp_t;

  cmd_t   exp_q[$];
  ack_t   ack_q[$];
  issue_t iss_q[$];
  rsp_t   got_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stab_err = 0;
  int oe_err = 0;

  bit            slave_en = 1'b0;
  bit            rand_wait = 1'b0;
  bit            force_en = 1'b0;
  int            wait_cyc = 0;
  logic [DW-1:0] force_data = '0;
  logic          force_evict = 1'b0;
  logic          man_valid = 1'b0;
  logic [DW-1:0] man_data = '0;
  logic          man_evict = 1'b0;
  logic [3:0]    op_tab [8];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cache slave: acknowledges after wait_cyc cycles, drops valid once request drops.
  // With slave_en low the bus follows the man_* values set by a test.
  initial begin : slave
    int   wcnt;
    ack_t a;
    wcnt = 0;
    valid = 1'b0; data_in = '0; evict = 1'b0;
    forever begin
      @(negedge clock);
      if (!slave_en || !reset_n) begin
        valid = man_valid; data_in = man_data; evict = man_evict; wcnt = 0;
      end else if (request && !valid) begin
        if (wcnt < wait_cyc) wcnt++;
        else begin
          a.data  = force_en ? force_data : DW'($urandom);
          a.evict = force_en ? force_evict : 1'($urandom);
          data_in = a.data; evict = a.evict; valid = 1'b1;
          ack_q.push_back(a);
          wcnt = 0;
          if (rand_wait) wait_cyc = $urandom_range(0, 4);
        end
      end else if (!request && valid) begin
        valid = 1'b0; evict = 1'b0;
      end
    end
  end

  // Bus monitor: logs each request rise and each response pulse.
  bit     req_q = 1'b0;
  issue_t cur;
  rsp_t   rr;
  always @(negedge clock) begin
    if (!reset_n) req_q = 1'b0;
    else begin
      if (request && !req_q) begin
        cur.op = operation; cur.addr = addr_out; cur.data = data_out;
        cur.oe = data_oe; cur.cyc = cyc;
        iss_q.push_back(cur);
      end else if (request && (operation !== cur.op || addr_out !== cur.addr ||
                               data_oe !== cur.oe || (cur.oe && data_out !== cur.data)))
        stab_err++;
      if (data_oe && !request) oe_err++;
      if (rsp_valid) begin
        rr.op = rsp_op; rr.data = rsp_data; rr.evict = rsp_evict; rr.cyc = cyc;
        got_q.push_back(rr);
      end
      req_q = request;
    end
  end

  function automatic rsp_t model(cmd_t c, ack_t a);
    rsp_t r;
    r.op    = c.op;
    r.data  = (c.op == 4'd0 || c.op == 4'd2) ? a.data : '0;
    r.evict = a.evict;
    r.cyc   = 0;
    return r;
  endfunction

  task automatic clear_q();
    exp_q.delete(); ack_q.delete(); iss_q.delete(); got_q.delete();
    stab_err = 0; oe_err = 0;
  endtask

  task automatic apply_reset();
    #2 reset_n = 1'b0;
    slave_en = 1'b0; man_valid = 1'b0; cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    clear_q();
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, output int acc_cyc);
    int n;
    @(negedge clock);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clock); n++; end
    total++;
    if (!cmd_ready) begin
      bad++; cmd_valid = 1'b0; acc_cyc = -1;
      $display("FAIL push_accept: cmd_ready stayed %b, needed 1 within 300 cycles", cmd_ready);
      return;
    end
    @(posedge clock); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    exp_q.push_back('{op, addr, data});
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    int k;
    k = 0;
    while (got_q.size() < n && k < 600) begin @(negedge clock); k++; end
    ok = (got_q.size() >= n);
  endtask

  task automatic wait_req(input logic lvl, output bit ok);
    int k;
    k = 0;
    do begin @(negedge clock); #1; k++; end while (request !== lvl && k < 300);
    ok = (request === lvl);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (request !== 1'b0) begin bad++; $display("FAIL reset_request got=%b exp=0", request); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL reset_data_oe got=%b exp=0", data_oe); end
    total++; if (addr_out !== '0 || operation !== '0 || data_out !== '0)
      begin bad++; $display("FAIL reset_bus got op=%h addr=%h data=%h exp all 0", operation, addr_out, data_out); end
    total++; if (rsp_op !== '0 || rsp_data !== '0 || rsp_evict !== 1'b0)
      begin bad++; $display("FAIL reset_rsp got op=%h data=%h ev=%b exp all 0", rsp_op, rsp_data, rsp_evict); end
  endtask

  task automatic test_latency();
    int acc; bit ok;
    clear_q();
    slave_en = 1'b1; wait_cyc = 0; rand_wait = 1'b0; force_en = 1'b0;
    push_cmd(4'd0, $urandom, '0, acc);
    wait_rsp(1, ok);
    total++;
    if (!ok || iss_q.size() != 1) begin bad++; $display("FAIL latency_timeout got rsp=%0d exp=1", got_q.size()); return; end
    total++; if (iss_q[0].cyc != acc + 1) begin bad++; $display("FAIL latency_request got edge=%0d exp=%0d", iss_q[0].cyc, acc + 1); end
    total++; if (got_q[0].cyc != acc + 3) begin bad++; $display("FAIL latency_rsp got edge=%0d exp=%0d", got_q[0].cyc, acc + 3); end
  endtask

  task automatic test_single_read();
    int acc; bit ok;
    clear_q();
    slave_en = 1'b1; wait_cyc = 3; force_en = 1'b1; force_data = 8'hA5; force_evict = 1'b0;
    push_cmd(4'd0, 32'h0000_1234, 8'h77, acc);
    wait_rsp(1, ok);
    repeat (3) @(negedge clock);
    total++;
    if (!ok || iss_q.size() != 1) begin bad++; $display("FAIL read_timeout got rsp=%0d exp=1", got_q.size()); return; end
    total++; if (iss_q[0].addr !== 32'h1234 || iss_q[0].oe !== 1'b0 || iss_q[0].op !== 4'd0)
      begin bad++; $display("FAIL read_issue got addr=%h oe=%b op=%h exp addr=1234 oe=0 op=0", iss_q[0].addr, iss_q[0].oe, iss_q[0].op); end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL read_pulses got=%0d exp=1", got_q.size()); end
    total++; if (got_q[0].data !== 8'hA5 || got_q[0].op !== 4'd0 || got_q[0].evict !== 1'b0)
      begin bad++; $display("FAIL read_rsp got data=%h op=%h ev=%b exp data=a5 op=0 ev=0", got_q[0].data, got_q[0].op, got_q[0].evict); end
    total++; if (got_q[0].cyc != iss_q[0].cyc + 5) begin bad++; $display("FAIL read_waits got edge=%0d exp=%0d", got_q[0].cyc, iss_q[0].cyc + 5); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL read_stable got=%0d exp=0", stab_err); end
  endtask

  task automatic test_write();
    int acc; bit ok;
    clear_q();
    slave_en = 1'b1; wait_cyc = 2; force_en = 1'b1; force_data = 8'hC7; force_evict = 1'b1;
    push_cmd(4'd1, 32'h10, 8'h3C, acc);
    wait_rsp(1, ok);
    repeat (4) @(negedge clock);
    total++;
    if (!ok || iss_q.size() != 1) begin bad++; $display("FAIL write_timeout got rsp=%0d exp=1", got_q.size()); return; end
    total++; if (iss_q[0].oe !== 1'b1 || iss_q[0].data !== 8'h3C || iss_q[0].addr !== 32'h10)
      begin bad++; $display("FAIL write_issue got oe=%b data=%h addr=%h exp oe=1 data=3c addr=10", iss_q[0].oe, iss_q[0].data, iss_q[0].addr); end
    total++; if (stab_err != 0 || oe_err != 0) begin bad++; $display("FAIL write_oe got stab=%0d oe=%0d exp 0/0", stab_err, oe_err); end
    total++; if (got_q[0].evict !== 1'b1 || got_q[0].data !== 8'h00 || got_q[0].op !== 4'd1)
      begin bad++; $display("FAIL write_rsp got ev=%b data=%h op=%h exp ev=1 data=00 op=1", got_q[0].evict, got_q[0].data, got_q[0].op); end
    total++; if (rsp_evict !== 1'b1 || rsp_op !== 4'd1 || data_oe !== 1'b0)
      begin bad++; $display("FAIL write_hold got ev=%b op=%h oe=%b exp 1/1/0", rsp_evict, rsp_op, data_oe); end
    force_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc; bit ok; rsp_t e; int n;
    clear_q();
    slave_en = 1'b0; man_valid = 1'b0; force_en = 1'b0; wait_cyc = 1;
    for (int i = 0; i < 5; i++) push_cmd(op_tab[$urandom_range(0, 7)], $urandom, DW'($urandom), acc);
    @(negedge clock);
    total++; if (cmd_ready !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL full_ready got ready=%b busy=%b exp ready=0 busy=1", cmd_ready, busy); end
    total++; if (iss_q.size() != 1) begin bad++; $display("FAIL full_inflight got=%0d exp=1", iss_q.size()); end
    slave_en = 1'b1;
    push_cmd(op_tab[$urandom_range(0, 7)], $urandom, DW'($urandom), acc);
    wait_rsp(6, ok);
    total++;
    if (!ok || iss_q.size() < 6 || ack_q.size() < 6) begin bad++; $display("FAIL b2b_timeout got rsp=%0d exp=6", got_q.size()); return; end
    n = 6;
    for (int i = 0; i < n; i++) begin
      e = model(exp_q[i], ack_q[i]);
      total++; if (iss_q[i].addr !== exp_q[i].addr || iss_q[i].op !== exp_q[i].op)
        begin bad++; $display("FAIL b2b_issue[%0d] got addr=%h op=%h exp addr=%h op=%h", i, iss_q[i].addr, iss_q[i].op, exp_q[i].addr, exp_q[i].op); end
      total++; if (got_q[i].op !== e.op || got_q[i].data !== e.data || got_q[i].evict !== e.evict)
        begin bad++; $display("FAIL b2b_rsp[%0d] got op=%h data=%h ev=%b exp op=%h data=%h ev=%b", i, got_q[i].op, got_q[i].data, got_q[i].evict, e.op, e.data, e.evict); end
    end
  endtask

  task automatic test_stale_ack();
    int acc; bit ok; int sv; rsp_t e;
    clear_q();
    slave_en = 1'b0; man_valid = 1'b0; wait_cyc = 0; rand_wait = 1'b0;
    push_cmd(op_tab[$urandom_range(0, 7)], $urandom, DW'($urandom), acc);
    push_cmd(op_tab[$urandom_range(0, 7)], $urandom, DW'($urandom), acc);
    wait_req(1'b1, ok);
    man_data = DW'($urandom); man_evict = 1'($urandom); man_valid = 1'b1;
    ack_q.push_back('{man_data, man_evict});
    wait_req(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL stale_handshake request got=%b exp=0", request); return; end
    man_valid = 1'b0;
    @(negedge clock); #1;
    man_valid = 1'b1;
    sv = 0;
    repeat (6) begin @(negedge clock); #1; if (request) sv++; end
    total++; if (sv != 0 || iss_q.size() != 1) begin bad++; $display("FAIL stale_hold got req_cycles=%0d rises=%0d exp 0/1", sv, iss_q.size()); end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL stale_pulses got=%0d exp=1", got_q.size()); end
    man_valid = 1'b0;
    slave_en = 1'b1;
    wait_rsp(2, ok);
    repeat (3) @(negedge clock);
    total++;
    if (!ok || got_q.size() != 2 || ack_q.size() != 2) begin bad++; $display("FAIL stale_done got rsp=%0d exp=2", got_q.size()); return; end
    for (int i = 0; i < 2; i++) begin
      e = model(exp_q[i], ack_q[i]);
      total++; if (got_q[i].op !== e.op || got_q[i].data !== e.data || got_q[i].evict !== e.evict)
        begin bad++; $display("FAIL stale_rsp[%0d] got op=%h data=%h ev=%b exp op=%h data=%h ev=%b", i, got_q[i].op, got_q[i].data, got_q[i].evict, e.op, e.data, e.evict); end
    end
  endtask

  task automatic test_random();
    int acc; bit ok; rsp_t e; int n;
    clear_q();
    n = 24;
    slave_en = 1'b1; rand_wait = 1'b1; force_en = 1'b0; wait_cyc = 1;
    for (int i = 0; i < n; i++) begin
      push_cmd(op_tab[$urandom_range(0, 7)], $urandom, DW'($urandom), acc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clock);
    end
    wait_rsp(n, ok);
    total++;
    if (!ok || iss_q.size() < n || ack_q.size() < n) begin bad++; $display("FAIL rand_timeout got rsp=%0d exp=%0d", got_q.size(), n); return; end
    for (int i = 0; i < n; i++) begin
      e = model(exp_q[i], ack_q[i]);
      total++; if (iss_q[i].addr !== exp_q[i].addr || iss_q[i].op !== exp_q[i].op ||
                   iss_q[i].oe !== (exp_q[i].op == 4'd1) || (iss_q[i].oe && iss_q[i].data !== exp_q[i].data))
        begin bad++; $display("FAIL rand_issue[%0d] got op=%h addr=%h oe=%b data=%h exp op=%h addr=%h data=%h", i, iss_q[i].op, iss_q[i].addr, iss_q[i].oe, iss_q[i].data, exp_q[i].op, exp_q[i].addr, exp_q[i].data); end
      total++; if (got_q[i].op !== e.op || got_q[i].data !== e.data || got_q[i].evict !== e.evict)
        begin bad++; $display("FAIL rand_rsp[%0d] got op=%h data=%h ev=%b exp op=%h data=%h ev=%b", i, got_q[i].op, got_q[i].data, got_q[i].evict, e.op, e.data, e.evict); end
    end
    total++; if (stab_err != 0 || oe_err != 0) begin bad++; $display("FAIL rand_stable got stab=%0d oe=%0d exp 0/0", stab_err, oe_err); end
    rand_wait = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc; bit ok;
    clear_q();
    slave_en = 1'b0; man_valid = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(op_tab[$urandom_range(0, 7)], $urandom, DW'($urandom), acc);
    wait_req(1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_request got=%b exp=1", request); end
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    total++; if (request !== 1'b0 || rsp_valid !== 1'b0)
      begin bad++; $display("FAIL rmid_async got req=%b rsp=%b exp 0/0", request, rsp_valid); end
    repeat (2) @(negedge clock);
    clear_q();
    reset_n = 1'b1;
    slave_en = 1'b1; wait_cyc = 0;
    repeat (10) @(negedge clock);
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1)
      begin bad++; $display("FAIL rmid_idle got busy=%b ready=%b exp 0/1", busy, cmd_ready); end
    total++; if (got_q.size() != 0 || iss_q.size() != 0)
      begin bad++; $display("FAIL rmid_discard got rsp=%0d req=%0d exp 0/0", got_q.size(), iss_q.size()); end
  endtask

`ifdef CACHE_REQ_STATS_EN
  task automatic test_stats();
    int acc; bit ok;
    logic [3:0] sops [5];
    logic       sevs [5];
    sops = '{4'd0, 4'd2, 4'd0, 4'd1, 4'd1};
    sevs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    slave_en = 1'b1; wait_cyc = 1; force_en = 1'b1; force_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      force_evict = sevs[i];
      push_cmd(sops[i], $urandom, DW'($urandom), acc);
      wait_rsp(i + 1, ok);
    end
    repeat (2) @(negedge clock);
    total++; if (stat_reads !== 32'd3 || stat_writes !== 32'd2 || stat_evicts !== 32'd1)
      begin bad++; $display("FAIL stats_count got r=%0d w=%0d e=%0d exp 3/2/1", stat_reads, stat_writes, stat_evicts); end
    force_evict = 1'b1;
    push_cmd(4'd8, $urandom, '0, acc);
    wait_rsp(6, ok);
    repeat (2) @(negedge clock);
    total++; if (stat_reads !== 32'd0 || stat_writes !== 32'd0 || stat_evicts !== 32'd0)
      begin bad++; $display("FAIL stats_clear got r=%0d w=%0d e=%0d exp 0/0/0", stat_reads, stat_writes, stat_evicts); end
    force_en = 1'b0;
  endtask
`endif

  initial begin
    op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd5, 4'd15};
    test_reset();
    test_latency();
    test_single_read();
    test_write();
    test_back_to_back();
    test_stale_ack();
    test_random();
    test_reset_mid();
`ifdef CACHE_REQ_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
